// File: rtl/lsu_bus_ctrl_pkg.sv
// Shared types and constants for the load/store bus controller.
package lsu_bus_ctrl_pkg;

  typedef logic [31:0] word_st;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } lsu_state_e;

  localparam logic [2:0] F3_BYTE = 3'b000;
  localparam logic [2:0] F3_HALF = 3'b001;
  localparam logic [2:0] F3_WORD = 3'b010;

endpackage

// File: rtl/lsu_bus_ctrl_lane_align.sv
// Byte-lane steering for the LSU: byte enables, store shift, load shift/mask
// and the misaligned/illegal-size flag.
module lsu_lane_align
  import lsu_bus_ctrl_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic [1:0] off,
  input  word_st     wdata,
  input  word_st     rdata,
  output logic [3:0] be,
  output word_st     wdata_sh,
  output word_st     rdata_al,
  output logic       bad
);

  word_st mask;

  always_comb begin
    be   = 4'b0000;
    bad  = 1'b0;
    mask = '0;
    case (funct3)
      F3_BYTE: begin
        be   = 4'b0001 << off;
        mask = 32'h0000_00ff;
      end
      F3_HALF: begin
        be   = 4'b0011 << {off[1], 1'b0};
        bad  = off[0];
        mask = 32'h0000_ffff;
      end
      F3_WORD: begin
        be   = 4'b1111;
        bad  = |off;
        mask = 32'hffff_ffff;
      end
      default: bad = 1'b1;
    endcase
  end

  assign wdata_sh = wdata << {off, 3'b000};
  assign rdata_al = (rdata >> {off, 3'b000}) & mask;

endmodule

// File: rtl/lsu_bus_ctrl.sv
// Load/store bus controller: one operation per transaction, word-addressed
// bus with byte enables, lane-aligned load return and timeout abort.
module lsu_bus_ctrl
  import lsu_bus_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       req_valid_i,
  output logic       req_ready_o,
  input  logic       req_we_i,
  input  word_st     req_addr_i,
  input  logic [2:0] req_funct3_i,
  input  word_st     req_wdata_i,
  output logic       mem_req_o,
  input  logic       mem_gnt_i,
  output logic       mem_we_o,
  output word_st     mem_addr_o,
  output logic [3:0] mem_be_o,
  output word_st     mem_wdata_o,
  input  logic       mem_rvalid_i,
  input  word_st     mem_rdata_i,
  output logic       rsp_valid_o,
  output word_st     rsp_rdata_o,
  output logic       rsp_err_o
);

  lsu_state_e state, state_nx;

  logic       we_q, err_q;
  word_st     addr_q, wdata_q, rdata_q;
  logic [2:0] f3_q;
  logic [7:0] cnt;

  logic [2:0] f3_sel;
  logic [1:0] off_sel;
  logic [3:0] be;
  word_st     wdata_sh, rdata_al;
  logic       bad, busy, complete, tmo;

  // In IDLE the aligner judges the incoming request; afterwards it serves
  // the captured one.
  assign f3_sel  = (state == IDLE) ? req_funct3_i    : f3_q;
  assign off_sel = (state == IDLE) ? req_addr_i[1:0] : addr_q[1:0];

  lsu_lane_align u_align (
    .funct3   (f3_sel),
    .off      (off_sel),
    .wdata    (wdata_q),
    .rdata    (rdata_q),
    .be       (be),
    .wdata_sh (wdata_sh),
    .rdata_al (rdata_al),
    .bad      (bad)
  );

  assign busy     = (state == REQ) || (state == WAIT);
  assign complete = ((state == REQ) && mem_gnt_i && mem_rvalid_i) ||
                    ((state == WAIT) && mem_rvalid_i);
  // A response arriving in the final allowed cycle still wins over the abort.
  assign tmo      = busy && !complete && (cnt == 8'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (req_valid_i) state_nx = bad ? RESP : REQ;
      REQ: begin
        if (complete || tmo) state_nx = RESP;
        else if (mem_gnt_i)  state_nx = WAIT;
      end
      WAIT: if (complete || tmo) state_nx = RESP;
      RESP: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    req_ready_o = (state == IDLE);
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_be_o    = '0;
    mem_wdata_o = '0;
    rsp_valid_o = 1'b0;
    rsp_rdata_o = '0;
    rsp_err_o   = 1'b0;
    case (state)
      REQ: begin
        mem_req_o   = 1'b1;
        mem_we_o    = we_q;
        mem_addr_o  = {addr_q[31:2], 2'b00};
        mem_be_o    = be;
        mem_wdata_o = wdata_sh;
      end
      RESP: begin
        rsp_valid_o = 1'b1;
        rsp_err_o   = err_q;
        rsp_rdata_o = (we_q || err_q) ? '0 : rdata_al;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      f3_q    <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (req_valid_i) begin
            we_q    <= req_we_i;
            addr_q  <= req_addr_i;
            f3_q    <= req_funct3_i;
            wdata_q <= req_wdata_i;
            rdata_q <= '0;
            err_q   <= bad;
          end
        end
        REQ, WAIT: begin
          cnt <= cnt + 8'd1;
          if (complete) begin
            rdata_q <= mem_rdata_i;
            err_q   <= 1'b0;
          end else if (tmo) begin
            err_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
